// File: rtl/axis_rate_monitor.sv
// Passive AXI-Stream rate monitor: accumulates bytes, beats, packets and cycles of a tapped
// stream, either cumulatively or in fixed-length windows that are captured into snapshots.
// Handshake: a beat is mon_tvalid & mon_tready in one cycle; the monitor observes only.
module axis_rate_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 64,
  parameter int WIN_WIDTH  = 32
) (
  input  logic                  s_aclk,
  input  logic                  s_aresetn,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic [KEEP_WIDTH-1:0] mon_tkeep,
  input  logic                  mon_tlast,
  input  logic                  cfg_mode,
  input  logic [WIN_WIDTH-1:0]  cfg_window,
  input  logic                  ctl_clear,
  input  logic                  ctl_freeze,
  output logic                  running,
  output logic [CNT_WIDTH-1:0]  byte_count,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  keep_err_count,
  output logic                  snap_valid,
  output logic [CNT_WIDTH-1:0]  snap_bytes,
  output logic [CNT_WIDTH-1:0]  snap_pkts,
  output logic [CNT_WIDTH-1:0]  snap_cycles
);

  // Keep lanes beyond the data bus cannot carry bytes.
  localparam int BYTE_LANES = (KEEP_WIDTH < DATA_WIDTH / 8) ? KEEP_WIDTH : DATA_WIDTH / 8;
  localparam int PW         = $clog2(BYTE_LANES + 1);
  localparam int WIDE       = CNT_WIDTH + WIN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   mode_q;
  logic [WIN_WIDTH-1:0]   win_len_q;
  logic [WIN_WIDTH-1:0]   win_cnt_q;

  logic                   beat;
  logic                   keep_bad;
  logic [PW-1:0]          beat_bytes;
  logic                   is_idle;
  logic                   count_en;
  logic                   mode_eff;
  logic [WIN_WIDTH-1:0]   cfg_len;
  logic [WIN_WIDTH-1:0]   win_len_eff;
  logic [WIN_WIDTH-1:0]   win_pos;
  logic                   win_close;
  logic [WIDE-1:0]        win_len_wide;
  logic [CNT_WIDTH-1:0]   win_len_cnt;
  logic [CNT_WIDTH-1:0]   byte_nxt, beat_nxt, pkt_nxt, cycle_nxt, err_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign beat = mon_tvalid & mon_tready;
  // A contiguous keep (2^n-1) has no bit in common with itself plus one.
  assign keep_bad = beat & (|(mon_tkeep & (mon_tkeep + KEEP_WIDTH'(1))));

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      beat_bytes = beat_bytes + PW'(mon_tkeep[i]);
    end
  end

  // The IDLE cycle that starts a run is window position 0 and uses the live config.
  assign is_idle     = (state_q == ST_IDLE);
  assign count_en    = !ctl_freeze && (!is_idle || beat);
  assign mode_eff    = is_idle ? cfg_mode : mode_q;
  assign cfg_len     = (cfg_window == '0) ? WIN_WIDTH'(1) : cfg_window;
  assign win_len_eff = is_idle ? cfg_len : win_len_q;
  assign win_pos     = is_idle ? '0 : win_cnt_q;
  assign win_close   = count_en && mode_eff && (win_pos == win_len_eff - WIN_WIDTH'(1));

  assign win_len_wide = {{CNT_WIDTH{1'b0}}, win_len_eff};
  assign win_len_cnt  = (win_len_wide > WIDE'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}}
                                                                   : win_len_wide[CNT_WIDTH-1:0];

  assign byte_nxt  = sat_add(byte_count, beat ? CNT_WIDTH'(beat_bytes) : '0);
  assign beat_nxt  = sat_add(beat_count, CNT_WIDTH'(beat));
  assign pkt_nxt   = sat_add(pkt_count, CNT_WIDTH'(beat & mon_tlast));
  assign cycle_nxt = sat_add(cycle_count, CNT_WIDTH'(1));
  assign err_nxt   = sat_add(keep_err_count, CNT_WIDTH'(keep_bad));

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ctl_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (beat && !ctl_freeze) state_d = ST_RUN;
        ST_RUN:    if (ctl_freeze)          state_d = ST_FROZEN;
        ST_FROZEN: if (!ctl_freeze)         state_d = ST_RUN;
        default:                            state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state_q == ST_RUN);
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      byte_count     <= '0;
      beat_count     <= '0;
      pkt_count      <= '0;
      cycle_count    <= '0;
      keep_err_count <= '0;
      snap_valid     <= 1'b0;
      snap_bytes     <= '0;
      snap_pkts      <= '0;
      snap_cycles    <= '0;
      mode_q         <= 1'b0;
      win_len_q      <= '0;
      win_cnt_q      <= '0;
    end else if (ctl_clear) begin
      byte_count     <= '0;
      beat_count     <= '0;
      pkt_count      <= '0;
      cycle_count    <= '0;
      keep_err_count <= '0;
      snap_valid     <= 1'b0;
      snap_bytes     <= '0;
      snap_pkts      <= '0;
      snap_cycles    <= '0;
      mode_q         <= 1'b0;
      win_len_q      <= '0;
      win_cnt_q      <= '0;
    end else begin
      snap_valid <= 1'b0;
      if (count_en) begin
        keep_err_count <= err_nxt;
        if (is_idle) begin
          mode_q    <= cfg_mode;
          win_len_q <= cfg_len;
        end
        if (win_close) begin
          snap_valid  <= 1'b1;
          snap_bytes  <= byte_nxt;
          snap_pkts   <= pkt_nxt;
          snap_cycles <= win_len_cnt;
          byte_count  <= '0;
          beat_count  <= '0;
          pkt_count   <= '0;
          cycle_count <= '0;
          win_cnt_q   <= '0;
          win_len_q   <= cfg_len;
        end else begin
          byte_count  <= byte_nxt;
          beat_count  <= beat_nxt;
          pkt_count   <= pkt_nxt;
          cycle_count <= cycle_nxt;
          if (mode_eff) win_cnt_q <= win_pos + WIN_WIDTH'(1);
        end
      end
    end
  end

endmodule
